// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: main+skid buffer under a valid/ready handshake.
// Optional perf counters (stall_cnt, bubble_cnt) when PIPE_PERF_CNT_EN is defined.
module pipe_stage_elastic #(
    parameter int DATA_W = 111,
    parameter int CTRL_W = 9
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_in_ready;
    logic [1:0]          r_occ;
    logic [CTRL_W-1:0]   r_main_ctrl;
    logic [DATA_W-1:0]   r_main_data;
    logic [CTRL_W-1:0]   r_skid_ctrl;
    logic [DATA_W-1:0]   r_skid_data;

    logic                w_out_valid;
    logic                w_push;
    logic                w_pop;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;
    logic [1:0]          w_occ_nx;

    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_push      = in_valid & r_in_ready;
    assign w_pop       = w_out_valid & out_ready;

    // Next-state and buffer-load decode; flush overrides everything but reset
    always_comb begin
        w_state_nx       = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nx     = ST_FULL;
                    w_load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_push && w_pop) begin
                    w_load_main_in = 1'b1;
                end else if (w_push) begin
                    w_state_nx  = ST_SKID;
                    w_load_skid = 1'b1;
                end else if (w_pop) begin
                    w_state_nx = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_pop) begin
                    w_state_nx       = ST_FULL;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nx = ST_EMPTY;
            end
        endcase
        if (FLUSH) begin
            w_state_nx       = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // Occupancy follows the next state so it is available as a register
    always_comb begin
        w_occ_nx = 2'd0;
        unique case (w_state_nx)
            ST_EMPTY: w_occ_nx = 2'd0;
            ST_FULL:  w_occ_nx = 2'd1;
            ST_SKID:  w_occ_nx = 2'd2;
            default:  w_occ_nx = 2'd0;
        endcase
    end

    // State register with registered in_ready and occupancy
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
            r_occ      <= 2'd0;
        end else begin
            r_state    <= w_state_nx;
            r_in_ready <= (w_state_nx != ST_SKID);
            r_occ      <= w_occ_nx;
        end
    end

    // Main entry: loads from input or skid; ctrl zeroed whenever stage empties
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (FLUSH) begin
            r_main_ctrl <= '0;
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_load_main_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
        end else if (w_state_nx == ST_EMPTY) begin
            r_main_ctrl <= '0;
        end
    end

    // Skid entry: catches the input when downstream stalls with main full
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (FLUSH) begin
            r_skid_ctrl <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_out_valid;
    assign out_ctrl  = r_main_ctrl;
    assign out_data  = r_main_data;
    assign occupancy = r_occ;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;
    logic             w_stall;
    logic             w_bubble;

    assign w_stall  = in_valid & ~r_in_ready;
    assign w_bubble = out_ready & ~w_out_valid;

    // Saturating stall counter; cleared only by reset, blind to flush
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Saturating bubble counter; cleared only by reset, blind to flush
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic.
// Perf counter checks are built when PIPE_PERF_CNT_EN is defined.
module tb_pipe_stage_elastic;

    localparam int DW = 111;
    localparam int CW = 9;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } exp_t;

    logic          CLK;
    logic          RST;
    logic          FLUSH;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_PERF_CNT_EN
    logic [3:0]    stall_cnt;
    logic [3:0]    bubble_cnt;
`endif

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    pipe_stage_elastic #(
        .DATA_W(DW),
        .CTRL_W(CW)
`ifdef PIPE_PERF_CNT_EN
        ,
        .CNT_W(4)
`endif
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .FLUSH(FLUSH),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_ctrl(in_ctrl),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl(out_ctrl),
        .out_data(out_data),
        .occupancy(occupancy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Offer one entry; queue its expectation once the stage will take it
    task automatic push_one(input logic [CW-1:0] c, input logic [DW-1:0] d);
        int  k;
        bit  ok;
        k  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = c;
        in_data  = d;
        while (!ok && k < 50) begin
            @(negedge CLK);
            if (in_ready) begin
                q.push_back({c, d});
                ok = 1'b1;
            end
            @(posedge CLK);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout: in_ready got 0 expected 1 (ctrl %0h)", c);
        end
    endtask

    // Monitor: every accepted output must match the head of the queue
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got ctrl %0h data %0h expected none",
                             out_ctrl, out_data);
                end else begin
                    e = q.pop_front();
                    check("out_ctrl", 128'(out_ctrl), 128'(e.c));
                    check("out_data", 128'(out_data), 128'(e.d));
                end
            end
            if (!out_valid) begin
                check("bubble_ctrl", 128'(out_ctrl), 128'd0);
            end
        end
    end

    initial begin
        RST       = 1'b1;
        FLUSH     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 9'h155;
        in_data   = 111'h5A5A;
        out_ready = 1'b0;

        // Reset held two cycles with in_valid high
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_ctrl", 128'(out_ctrl), 128'd0);
        check("rst_out_data", 128'(out_data), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd1);
        check("rst_occ", 128'(occupancy), 128'd0);
`ifdef PIPE_PERF_CNT_EN
        check("rst_stall", 128'(stall_cnt), 128'd0);
        check("rst_bubble", 128'(bubble_cnt), 128'd0);
`endif
        RST = 1'b0;
        push_one(9'h155, 111'h5A5A);
        check("first_occ", 128'(occupancy), 128'd1);
        check("first_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        cyc();
        check("first_drain_occ", 128'(occupancy), 128'd0);

        // Stream 1..4 at full rate
        for (int i = 1; i <= 4; i++) begin
            push_one(9'(i), 111'(i));
            check("stream_in_ready", 128'(in_ready), 128'd1);
            check("stream_occ", 128'(occupancy), 128'd1);
        end
        cyc();
        check("stream_drain_occ", 128'(occupancy), 128'd0);

        // Backpressure: A,B fill both entries, C waits upstream
        out_ready = 1'b0;
        push_one(9'h0A1, 111'hAAAA);
        push_one(9'h0B2, 111'hBBBB);
        check("bp_occ", 128'(occupancy), 128'd2);
        check("bp_in_ready", 128'(in_ready), 128'd0);
        check("bp_head", 128'(out_data), 128'h0AAAA);
        in_valid = 1'b1;
        in_ctrl  = 9'h0C3;
        in_data  = 111'hCCCC;
        cyc();
        cyc();
        check("bp_hold_occ", 128'(occupancy), 128'd2);
        check("bp_hold_ready", 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        push_one(9'h0C3, 111'hCCCC);
        cyc();
        check("bp_drain_occ", 128'(occupancy), 128'd0);

        // Flush in SKID with a live input
        out_ready = 1'b0;
        push_one(9'h0D1, 111'hD1D1);
        push_one(9'h0D2, 111'hD2D2);
        check("fl_pre_occ", 128'(occupancy), 128'd2);
        in_valid = 1'b1;
        in_ctrl  = 9'h1FF;
        in_data  = 111'hF00D;
        FLUSH    = 1'b1;
        cyc();
        FLUSH    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 128'(out_valid), 128'd0);
        check("fl_out_ctrl", 128'(out_ctrl), 128'd0);
        check("fl_occ", 128'(occupancy), 128'd0);
        check("fl_in_ready", 128'(in_ready), 128'd1);
        q.delete();
        out_ready = 1'b1;
        repeat (3) cyc();
        check("fl_after_occ", 128'(occupancy), 128'd0);

        // Flush together with a pop: head delivered, rest dropped
        out_ready = 1'b0;
        push_one(9'h0E1, 111'hE1E1);
        push_one(9'h0E2, 111'hE2E2);
        out_ready = 1'b1;
        FLUSH     = 1'b1;
        cyc();
        FLUSH = 1'b0;
        check("flpop_left", 128'(q.size()), 128'd1);
        q.delete();
        check("flpop_occ", 128'(occupancy), 128'd0);
        check("flpop_valid", 128'(out_valid), 128'd0);

        // Reset together with flush
        out_ready = 1'b0;
        push_one(9'h0F1, 111'hF1F1);
        RST      = 1'b1;
        FLUSH    = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 9'h1FF;
        in_data  = 111'hBEEF;
        cyc();
        RST      = 1'b0;
        FLUSH    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        check("rf_out_valid", 128'(out_valid), 128'd0);
        check("rf_out_ctrl", 128'(out_ctrl), 128'd0);
        check("rf_out_data", 128'(out_data), 128'd0);
        check("rf_in_ready", 128'(in_ready), 128'd1);
        check("rf_occ", 128'(occupancy), 128'd0);

`ifdef PIPE_PERF_CNT_EN
        check("rf_stall", 128'(stall_cnt), 128'd0);
        out_ready = 1'b1;
        repeat (3) cyc();
        check("bubble_3", 128'(bubble_cnt), 128'd3);
        out_ready = 1'b0;
        push_one(9'h011, 111'h1111);
        push_one(9'h022, 111'h2222);
        in_valid = 1'b1;
        in_ctrl  = 9'h033;
        in_data  = 111'h3333;
        repeat (5) cyc();
        check("stall_5", 128'(stall_cnt), 128'd5);
        repeat (15) cyc();
        check("stall_sat", 128'(stall_cnt), 128'd15);
        check("stall_occ", 128'(occupancy), 128'd2);
        in_valid = 1'b0;
        FLUSH    = 1'b1;
        cyc();
        FLUSH = 1'b0;
        q.delete();
        check("stall_after_flush", 128'(stall_cnt), 128'd15);
        check("bubble_hold", 128'(bubble_cnt), 128'd3);
`endif

        out_ready = 1'b1;
        repeat (4) cyc();
        check("queue_empty", 128'(q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
